motor_drive_guard: RTL and testbench
====================================

Name: motor_drive_guard

Overview:
- Safety stage directly downstream of the system's two DC-motor conduits: left and right in1/in2/pwm.
- Registers each channel's commanded direction and PWM, and inserts a coast dead-time on every forward<->reverse reversal.
- Latches a fault on external e-stop or stuck-high PWM; a faulted channel is driven to short brake until explicitly cleared.
- Its outputs drive the H-bridge pins directly.

Parameters:
- DEADTIME_CYC, 5000: coast cycles inserted on a FWD<->REV reversal (100 us at 50 MHz); must be >= 1.
- PWM_MAX_HIGH, 2500000: consecutive pwm-high cycles that declare stuck PWM (50 ms); 0 disables the check.

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  reset, asynchronous, active-low
- l_in1_i, l_in2_i, l_pwm_i  in  1 each  left-channel command (from dc_motor_left conduit)
- r_in1_i, r_in2_i, r_pwm_i  in  1 each  right-channel command
- estop_n_i  in  1  external e-stop pin, asynchronous, low = stop
- clear_fault_i  in  1  fault clear request (level); the rising edge acts
- l_in1_o, l_in2_o, l_pwm_o  out  1 each  left H-bridge drive
- r_in1_o, r_in2_o, r_pwm_o  out  1 each  right H-bridge drive
- fault_o  out  2  latched fault; bit0 = left, bit1 = right
- dead_o  out  2  channel currently in dead-time

Behaviour:
- Reset: all in/pwm outputs 0 (coast); fault_o = 0; dead_o = 0; both channels in RUN with driven direction COAST; counters 0.
- Direction decode of {in1,in2}:
  - 10 = FWD
  - 01 = REV
  - 00 = COAST
  - 11 = BRAKE
- estop_n_i and clear_fault_i each pass through a 2-FF synchronizer. clear edge detection is done on the synchronized signal.
- Each channel runs an independent FSM (RUN, DEAD, FAULT) with one shared synchronized e-stop.
- RUN:
  - Outputs = registered inputs; 1-cycle latency from input to output.
  - A request of FWD while driving REV, or REV while driving FWD, enters DEAD instead.
  - Any transition involving COAST or BRAKE passes through with no dead-time.
- DEAD:
  - Outputs 00, pwm 0; dead_o bit = 1; counter loaded with DEADTIME_CYC-1 on entry.
  - Counter decrements each cycle. At 0 the channel returns to RUN and drives the request present in that cycle.
  - A request changing back during DEAD does not shorten the dead-time.
- Stuck-PWM check:
  - Per-channel counter increments while in RUN with pwm_i = 1 and direction FWD or REV.
  - Counter clears when pwm_i = 0 or on leaving RUN.
  - Reaching PWM_MAX_HIGH moves the channel to FAULT in the same cycle.
- E-stop: synchronized estop low moves both channels to FAULT from any state. Outputs are in brake no later than 3 clocks after the pin falls.
- FAULT:
  - Outputs in1 = 1, in2 = 1, pwm = 0 (short brake); fault_o bit = 1; dead_o bit = 0.
  - Exit to RUN, with driven direction COAST, only on a synchronized clear_fault rising edge while estop is high and the channel's request is COAST.
  - Otherwise the clear edge is ignored; it is not remembered.
- Simultaneous events:
  - Fault condition and clear edge in the same cycle: fault wins.
  - E-stop during DEAD: FAULT, and the dead counter is abandoned.
  - Reset mid-dead-time: immediate coast with all state cleared.
- Counters saturate, never wrap. Dead counter width = clog2(DEADTIME_CYC); stuck counter width = clog2(PWM_MAX_HIGH+1).

Optional Feature:
- Macro: MOTOR_GUARD_EVENT_CNT_EN.
- Defined:
  - Adds output port guard_events_o [15:0]: a saturating count (stops at 16'hFFFF) of DEAD entries plus FAULT entries, summed over both channels.
  - If both channels enter in the same cycle, it adds 2.
  - Cleared only by reset.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
- Bench params DEADTIME_CYC=4, PWM_MAX_HIGH=16. Release reset, left input {10, pwm toggling} -> l_in1_o=1, l_in2_o=0, l_pwm_o follows l_pwm_i delayed 1 clk; fault_o=00, dead_o=00.
- Left FWD, then switch input to REV -> outputs 00/pwm 0 and dead_o[0]=1 for exactly 4 clks, then 01 driven; right channel unaffected throughout.
- Left FWD -> COAST -> REV on consecutive clks -> no dead-time; outputs follow with 1-clk latency; dead_o stays 00.
- Left FWD with l_pwm_i held 1 -> at the 16th high cycle fault_o[0]=1 and outputs 11/pwm 0. Clear edge with request FWD -> stays FAULT. Request 00 plus clear edge -> RUN, outputs 00.
- Pull estop_n_i low mid-dead-time on the right channel -> both channels at 11/pwm 0 within 3 clks; fault_o=11. Clear edge while estop is still low -> ignored.
- With MOTOR_GUARD_EVENT_CNT_EN: 3 reversals plus 1 e-stop (both channels) -> guard_events_o=5. Assert reset mid-dead-time -> all outputs 0 and guard_events_o=0 immediately.

Source files
------------

// File: rtl/motor_drive_guard.sv
// motor_drive_guard: registered H-bridge drive with reversal dead-time and latched fault/brake.
// Ports:
//   clk_clk, reset_reset_n          clock, asynchronous active-low reset
//   l_/r_ in1_i, in2_i, pwm_i       per-channel direction/PWM command
//   estop_n_i                       asynchronous e-stop pin, low = stop
//   clear_fault_i                   fault clear request, rising edge acts
//   l_/r_ in1_o, in2_o, pwm_o       per-channel H-bridge drive
//   fault_o[1:0], dead_o[1:0]       per-channel fault latch / dead-time flag (bit0 = left)
//   guard_events_o[15:0]            DEAD+FAULT entry count, only with MOTOR_GUARD_EVENT_CNT_EN
module motor_drive_guard #(
  parameter int DEADTIME_CYC = 5000,
  parameter int PWM_MAX_HIGH = 2500000
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        l_in1_i,
  input  logic        l_in2_i,
  input  logic        l_pwm_i,
  input  logic        r_in1_i,
  input  logic        r_in2_i,
  input  logic        r_pwm_i,
  input  logic        estop_n_i,
  input  logic        clear_fault_i,
  output logic        l_in1_o,
  output logic        l_in2_o,
  output logic        l_pwm_o,
  output logic        r_in1_o,
  output logic        r_in2_o,
  output logic        r_pwm_o,
  output logic [1:0]  fault_o,
  output logic [1:0]  dead_o
`ifdef MOTOR_GUARD_EVENT_CNT_EN
  ,output logic [15:0] guard_events_o
`endif
);
  localparam int DW = (DEADTIME_CYC > 1) ? $clog2(DEADTIME_CYC) : 1;
  localparam int SW = (PWM_MAX_HIGH > 0) ? $clog2(PWM_MAX_HIGH + 1) : 1;
  typedef enum logic [1:0] {RUN, DEAD, FAULT} st_t;
  logic [1:0] estop_sq, clr_sq;
  logic       clr_prev_q, estop_s, clr_edge;
  logic [2:0] cmd [2];
  logic [2:0] drv [2];
  logic [1:0] ent;
  // E-stop synchronizer resets to "released" so leaving reset does not fault the channels.
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      estop_sq   <= 2'b11;
      clr_sq     <= 2'b00;
      clr_prev_q <= 1'b0;
    end else begin
      estop_sq   <= {estop_sq[0], estop_n_i};
      clr_sq     <= {clr_sq[0], clear_fault_i};
      clr_prev_q <= clr_sq[1];
    end
  assign estop_s  = estop_sq[1];
  assign clr_edge = clr_sq[1] & ~clr_prev_q;
  assign cmd[0] = {l_in1_i, l_in2_i, l_pwm_i};
  assign cmd[1] = {r_in1_i, r_in2_i, r_pwm_i};
  for (genvar c = 0; c < 2; c++) begin : g_ch
    st_t            st_q, st_d;
    logic [2:0]     out_q, out_d;
    logic [DW-1:0]  dcnt_q, dcnt_d;
    logic [SW-1:0]  scnt_q, scnt_d;
    logic [1:0]     req;
    logic           pwm, rev, scnt_inc, stuck;
    always_ff @(posedge clk_clk or negedge reset_reset_n)
      if (!reset_reset_n) begin
        st_q   <= RUN;
        out_q  <= 3'b000;
        dcnt_q <= '0;
        scnt_q <= '0;
      end else begin
        st_q   <= st_d;
        out_q  <= out_d;
        dcnt_q <= dcnt_d;
        scnt_q <= scnt_d;
      end
    assign req      = cmd[c][2:1];
    assign pwm      = cmd[c][0];
    // Only a direct FWD<->REV swap of the driven direction needs coast time.
    assign rev      = (req == 2'b10 && out_q[2:1] == 2'b01) || (req == 2'b01 && out_q[2:1] == 2'b10);
    assign scnt_inc = (PWM_MAX_HIGH != 0) && pwm && (req == 2'b10 || req == 2'b01);
    assign stuck    = scnt_inc && (scnt_q == SW'(PWM_MAX_HIGH - 1));
    always_comb begin
      st_d   = st_q;
      out_d  = out_q;
      dcnt_d = '0;
      scnt_d = '0;
      if (!estop_s) begin
        st_d  = FAULT;
        out_d = 3'b110;
      end else if (st_q == RUN) begin
        if (stuck) begin
          st_d  = FAULT;
          out_d = 3'b110;
        end else if (rev) begin
          st_d   = DEAD;
          out_d  = 3'b000;
          dcnt_d = DW'(DEADTIME_CYC - 1);
        end else begin
          out_d  = cmd[c];
          scnt_d = !pwm ? '0 : scnt_inc ? scnt_q + SW'(1) : scnt_q;
        end
      end else if (st_q == DEAD) begin
        if (dcnt_q == '0) begin
          st_d  = RUN;
          out_d = cmd[c];
        end else dcnt_d = dcnt_q - DW'(1);
      end else if (clr_edge && req == 2'b00) begin
        st_d  = RUN;
        out_d = 3'b000;
      end
    end
    assign drv[c]     = out_q;
    assign dead_o[c]  = st_q == DEAD;
    assign fault_o[c] = st_q == FAULT;
    assign ent[c]     = (st_d != st_q) && (st_d != RUN);
  end
  assign {l_in1_o, l_in2_o, l_pwm_o} = drv[0];
  assign {r_in1_o, r_in2_o, r_pwm_o} = drv[1];
`ifdef MOTOR_GUARD_EVENT_CNT_EN
  logic [15:0] ev_q, ev_d;
  logic [16:0] ev_sum;
  assign ev_sum = {1'b0, ev_q} + 17'(ent[0]) + 17'(ent[1]);
  assign ev_d   = ev_sum[16] ? 16'hFFFF : ev_sum[15:0];
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) ev_q <= '0;
    else ev_q <= ev_d;
  assign guard_events_o = ev_q;
`else
  logic unused_ent;
  assign unused_ent = ^ent;
`endif
endmodule

// File: tb/tb_motor_drive_guard.sv
// tb_motor_drive_guard: directed self-checking bench for motor_drive_guard.
module tb_motor_drive_guard;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic l_in1 = 0, l_in2 = 0, l_pwm = 0, r_in1 = 0, r_in2 = 0, r_pwm = 0;
  logic estop_n = 1'b1, clr = 1'b0;
  logic l_in1_o, l_in2_o, l_pwm_o, r_in1_o, r_in2_o, r_pwm_o;
  logic [1:0] fault_o, dead_o;
`ifdef MOTOR_GUARD_EVENT_CNT_EN
  logic [15:0] guard_events_o;
`endif
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  motor_drive_guard #(.DEADTIME_CYC(4), .PWM_MAX_HIGH(16)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .l_in1_i(l_in1), .l_in2_i(l_in2), .l_pwm_i(l_pwm),
    .r_in1_i(r_in1), .r_in2_i(r_in2), .r_pwm_i(r_pwm),
    .estop_n_i(estop_n), .clear_fault_i(clr),
    .l_in1_o(l_in1_o), .l_in2_o(l_in2_o), .l_pwm_o(l_pwm_o),
    .r_in1_o(r_in1_o), .r_in2_o(r_in2_o), .r_pwm_o(r_pwm_o),
    .fault_o(fault_o), .dead_o(dead_o)
`ifdef MOTOR_GUARD_EVENT_CNT_EN
    , .guard_events_o(guard_events_o)
`endif
  );
  wire [2:0] lo = {l_in1_o, l_in2_o, l_pwm_o};
  wire [2:0] ro = {r_in1_o, r_in2_o, r_pwm_o};
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic setl(input logic [2:0] v);
    {l_in1, l_in2, l_pwm} = v;
  endtask
  task automatic setr(input logic [2:0] v);
    {r_in1, r_in2, r_pwm} = v;
  endtask
  initial begin
    #1;
    chk("rst_lo", 16'(lo), 16'h0);
    chk("rst_ro", 16'(ro), 16'h0);
    chk("rst_fault", 16'(fault_o), 16'h0);
    chk("rst_dead", 16'(dead_o), 16'h0);
    tick(2);
    rst_n = 1'b1;
    setr(3'b100);
    setl(3'b101); tick(1); chk("fwd_pwm1", 16'(lo), 16'h5);
    setl(3'b100); tick(1); chk("fwd_pwm0", 16'(lo), 16'h4);
    setl(3'b101); tick(1); chk("fwd_pwm1b", 16'(lo), 16'h5);
    setl(3'b100); tick(1); chk("fwd_pwm0b", 16'(lo), 16'h4);
    chk("run_fault", 16'(fault_o), 16'h0);
    chk("run_dead", 16'(dead_o), 16'h0);
    chk("run_ro", 16'(ro), 16'h4);
    setl(3'b010); tick(1);
    for (int i = 0; i < 4; i++) begin
      chk("dead_flag", 16'(dead_o), 16'h1);
      chk("dead_lo", 16'(lo), 16'h0);
      chk("dead_ro", 16'(ro), 16'h4);
      tick(1);
    end
    chk("dead_exit_lo", 16'(lo), 16'h2);
    chk("dead_exit_flag", 16'(dead_o), 16'h0);
    setl(3'b000); tick(1); chk("coast1", 16'(lo), 16'h0);
    setl(3'b100); tick(1); chk("coast_fwd", 16'(lo), 16'h4);
    setl(3'b000); tick(1); chk("coast2", 16'(lo), 16'h0);
    setl(3'b010); tick(1); chk("coast_rev", 16'(lo), 16'h2);
    chk("coast_nodead", 16'(dead_o), 16'h0);
    setl(3'b000); tick(1);
    setl(3'b101); tick(15);
    chk("stuck_pre_fault", 16'(fault_o), 16'h0);
    chk("stuck_pre_lo", 16'(lo), 16'h5);
    tick(1);
    chk("stuck_fault", 16'(fault_o), 16'h1);
    chk("stuck_lo", 16'(lo), 16'h6);
    chk("stuck_ro", 16'(ro), 16'h4);
    clr = 1'b1; tick(4);
    chk("clr_fwd_ignored", 16'(fault_o), 16'h1);
    clr = 1'b0; tick(3);
    setl(3'b000); clr = 1'b1; tick(3);
    chk("clr_ok_fault", 16'(fault_o), 16'h0);
    chk("clr_ok_lo", 16'(lo), 16'h0);
    clr = 1'b0; tick(3);
    setr(3'b010); tick(1);
    chk("r_dead", 16'(dead_o), 16'h2);
    estop_n = 1'b0; tick(3);
    chk("estop_lo", 16'(lo), 16'h6);
    chk("estop_ro", 16'(ro), 16'h6);
    chk("estop_fault", 16'(fault_o), 16'h3);
    chk("estop_dead", 16'(dead_o), 16'h0);
    setr(3'b000); clr = 1'b1; tick(4);
    chk("clr_estop_ignored", 16'(fault_o), 16'h3);
    clr = 1'b0; tick(3);
    estop_n = 1'b1; tick(3);
    chk("estop_rel_held", 16'(fault_o), 16'h3);
    clr = 1'b1; tick(3);
    chk("clr_both", 16'(fault_o), 16'h0);
    chk("clr_both_ro", 16'(ro), 16'h0);
    clr = 1'b0; tick(3);
`ifdef MOTOR_GUARD_EVENT_CNT_EN
    chk("events", guard_events_o, 16'd5);
`endif
    setl(3'b100); tick(1);
    setl(3'b010); tick(2);
    chk("pre_rst_dead", 16'(dead_o), 16'h1);
    rst_n = 1'b0; #1;
    chk("rst_mid_lo", 16'(lo), 16'h0);
    chk("rst_mid_ro", 16'(ro), 16'h0);
    chk("rst_mid_dead", 16'(dead_o), 16'h0);
    chk("rst_mid_fault", 16'(fault_o), 16'h0);
`ifdef MOTOR_GUARD_EVENT_CNT_EN
    chk("rst_events", guard_events_o, 16'd0);
`endif
    setl(3'b000); tick(2);
    rst_n = 1'b1; tick(2);
    chk("post_rst_lo", 16'(lo), 16'h0);
    chk("post_rst_fault", 16'(fault_o), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
